// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Integer register file for the scalar pipeline: NREGS x XLEN entries with two
// combinational read ports, one write port, and write-through bypass. A
// per-register busy scoreboard tracks destinations of issued but not yet
// written-back instructions, and the block raises issue_stall on RAW/WAW
// hazards. Register SP_IDX resets to SP_INIT. Register 0 is optionally
// hardwired to zero.
//
// Ports:
//   clk, rstn            clock (rising edge) / asynchronous active-low reset
//   rd_addr1/2           read addresses, also the hazard-check sources
//   rd_data1/2           read data, with bypass from the WB write port
//   rd_busy1/2           source has a pending write not satisfied this cycle
//   issue_valid/wr/dst   ID issue request, writes-destination flag, destination
//   issue_stall          issue blocked this cycle
//   wr_en/addr/data      WB write port
//   flush                clears every busy bit
// -----------------------------------------------------------------------------
module rf_scoreboard #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int SP_IDX   = 2,
  parameter int SP_INIT  = 2048
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  output logic            rd_busy1,
  output logic            rd_busy2,
  input  logic            issue_valid,
  input  logic            issue_wr,
  input  logic [AW-1:0]   issue_dst,
  output logic            issue_stall,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            flush
);

  localparam bit              ZR        = (ZERO_REG != 0);
  localparam logic [XLEN-1:0] SP_INIT_V = XLEN'(SP_INIT);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic             w_wr_ok;
  logic             w_dst_conflict;
  logic             w_issue_fire;
  logic [NREGS-1:0] w_busy_nxt;

  // A write to x0 is dropped entirely when x0 is hardwired, so it must not
  // bypass onto the read ports either.
  assign w_wr_ok = wr_en && !(ZR && (wr_addr == '0));

  always_comb begin
    if (ZR && (rd_addr1 == '0))                 rd_data1 = '0;
    else if (w_wr_ok && (wr_addr == rd_addr1))  rd_data1 = wr_data;
    else                                        rd_data1 = r_regs[rd_addr1];

    if (ZR && (rd_addr2 == '0))                 rd_data2 = '0;
    else if (w_wr_ok && (wr_addr == rd_addr2))  rd_data2 = wr_data;
    else                                        rd_data2 = r_regs[rd_addr2];
  end

  // A same-cycle WB to the register satisfies the hazard, so it is not busy.
  // busy[0] is never set when x0 is hardwired, so x0 never reports busy.
  assign rd_busy1       = r_busy[rd_addr1] && !(wr_en && (wr_addr == rd_addr1));
  assign rd_busy2       = r_busy[rd_addr2] && !(wr_en && (wr_addr == rd_addr2));
  assign w_dst_conflict = issue_wr && r_busy[issue_dst] &&
                          !(wr_en && (wr_addr == issue_dst));
  assign issue_stall    = issue_valid && (rd_busy1 || rd_busy2 || w_dst_conflict);
  assign w_issue_fire   = issue_valid && !issue_stall;

  // Flush dominates everything; otherwise WB clears first and issue sets
  // afterwards so that a set wins over a clear on the same index.
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      if (wr_en)
        w_busy_nxt[wr_addr] = 1'b0;
      if (w_issue_fire && issue_wr && !(ZR && (issue_dst == '0)))
        w_busy_nxt[issue_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= (i == SP_IDX) ? SP_INIT_V : '0;
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Parametrised integer register file for the scalar pipeline: NREGS x XLEN, two read ports, one write port.
- Adds write-through bypass, a configurable stack-pointer reset value, and a per-register busy scoreboard.
- Decode uses the scoreboard to detect RAW/WAW hazards and stall issue; writeback clears busy bits.
- Sits between ID (reads, issue) and WB (write).

Parameters:
XLEN, 64, data width of each register
NREGS, 32, number of architectural registers (power of two)
AW, 5, address width, log2(NREGS)
ZERO_REG, 1, 1 = register 0 hardwired to zero (writes dropped, never busy)
SP_IDX, 2, index of the stack pointer register
SP_INIT, 2048, reset value of register SP_IDX

Ports:
clk  in  1  clock; all state updates on rising edge
rstn  in  1  asynchronous active-low reset
rd_addr1  in  AW  read port 1 address (also source 1 for hazard check)
rd_addr2  in  AW  read port 2 address (also source 2 for hazard check)
rd_data1  out  XLEN  read port 1 data
rd_data2  out  XLEN  read port 2 data
rd_busy1  out  1  source 1 has a pending write not satisfied this cycle
rd_busy2  out  1  source 2 has a pending write not satisfied this cycle
issue_valid  in  1  ID requests issue of an instruction
issue_wr  in  1  issuing instruction writes a destination
issue_dst  in  AW  destination of issuing instruction
issue_stall  out  1  issue blocked this cycle
wr_en  in  1  WB write enable
wr_addr  in  AW  WB destination
wr_data  in  XLEN  WB data
flush  in  1  pipeline flush: clear all busy bits

Behaviour:
- Reset (async, rstn=0): every register 0 except register SP_IDX = SP_INIT; all busy bits 0. Outputs follow combinationally: rd_data = reset contents, rd_busy* = 0, issue_stall = 0.
- Reset asserted mid-operation discards pending writes and busy state immediately. Release is synchronous to the next rising edge.
- Write: on the rising edge with wr_en=1, register[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read is combinational, zero latency.
  - If wr_en=1, wr_addr=rd_addrN, and the write is not dropped, rd_dataN = wr_data (bypass).
  - Otherwise rd_dataN = register[rd_addrN].
  - Register 0 reads 0 when ZERO_REG=1.
- rd_busyN = busy[rd_addrN] and not (wr_en and wr_addr=rd_addrN). This is always 0 for register 0 when ZERO_REG=1.
- dst_conflict = issue_wr and busy[issue_dst] and not (wr_en and wr_addr=issue_dst).
- issue_stall = issue_valid and (rd_busy1 or rd_busy2 or dst_conflict). Combinational.
- Issue fires when issue_valid=1 and issue_stall=0. Busy bits update on the rising edge in this priority order:
  1. flush=1: all busy bits cleared; a same-cycle issue sets nothing.
  2. Else wr_en=1: busy[wr_addr] cleared.
  3. Then, if issue fires with issue_wr=1 (and issue_dst≠0 when ZERO_REG=1): busy[issue_dst] set. Set wins over clear on the same index.
- WB write to a non-busy register is legal: data is written and busy stays 0.
- Flush never modifies register data. A WB write in the flush cycle still updates data.
- Hazards are only detected on the read addresses presented at rd_addr1/2. ID must present the issuing instruction's sources there.

Test Plan:
- Reset: rstn=0 then 1 -> reg2 reads 2048, regs 0/1/3..31 read 0, issue_stall=0.
- Write then bypass: wr_en=1, wr_addr=5, wr_data=0xDEAD, rd_addr1=5 in the same cycle -> rd_data1=0xDEAD that cycle and 0xDEAD after the edge with wr_en=0.
- Zero register: write 0x1234 to x0, then issue with issue_dst=0 -> rd_data reads 0, no busy bit set, issue_stall=0.
- RAW hazard: issue dst=7, next cycle rd_addr2=7 with issue_valid=1 -> rd_busy2=1, issue_stall=1. WB to 7 with 0x55 -> in that cycle rd_busy2=0, issue_stall=0, rd_data2=0x55.
- Same-cycle clear/set: busy[9]=1, WB to 9 while issuing dst=9 -> no stall; after the edge busy[9]=1.
- Flush: busy on regs 3,4,10, flush=1 with issue dst=11 -> after the edge all busy bits 0; data unchanged.
